htpa_target_builder: RTL and testbench
======================================

// Module: htpa_target_builder
// PURPOSE
//  Writer side of the HTPA target-slot interface consumed by the box/overlay drawer.
//  Takes the per-frame stream of thresholded thermal pixels and clusters hot pixels into up to N_TGT bounding boxes.
//  At frame end it publishes a stable, double-buffered set of slots: busy, packed box {xo,yo,xn,yn} and a fire flag per slot.
//  Sits between the pixel threshold stage and the drawer; all slot buses change only at publish.
// PARAMETERS
//  N_TGT    20  number of target slots (drawer WIDTH+1)
//  MARGIN   2   merge distance in pixels: hot pixel joins a box if within MARGIN of its edges
//  MIN_PIX  4   minimum hot pixels for a slot to be published busy
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  frame_start  in   1        one-cycle pulse, first cycle of a frame
//  frame_end    in   1        one-cycle pulse, last cycle of a frame
//  pix_valid    in   1        pix_* qualified this cycle
//  pix_x        in   7        pixel column 0..127
//  pix_y        in   6        pixel row 0..63
//  pix_hot      in   1        pixel above target threshold
//  pix_fire     in   1        pixel above fire threshold (only meaningful with pix_hot)
//  busy         out  N_TGT    published slot valid
//  box          out  26xN_TGT per slot {xo[25:19],yo[18:13],xn[12:6],yn[5:0]}
//  fire_out     out  N_TGT    published slot contains >=1 fire pixel
//  overflow     out  1        published: a hot pixel found no slot in last frame
//  frame_done   out  1        one-cycle pulse in the cycle the published outputs update
// BEHAVIOUR
//  Reset: all outputs 0; working set cleared; FSM = IDLE.
//  FSM: IDLE -frame_start-> ACQ; ACQ -frame_end-> PUB; PUB -> IDLE (1 cycle); frame_start in PUB -> ACQ.
//  frame_start (any state): clear working busy/count/fire/overflow. A pix_valid in the same cycle is applied
//   after the clear, as the frame's first pixel.
//  Pixels are processed only in ACQ (including the frame_start and frame_end cycles), one per cycle, with no stall.
//  Match: working slot i is busy and (pix_x+MARGIN >= xo) && (pix_x <= xn+MARGIN) && same test for y.
//   All compares are done 1 bit wider, so there is no wrap at 0 or at 127/63.
//  Lowest-index matching slot wins: xo=min, xn=max, yo=min, yn=max with the pixel; count+=1 saturating at 255;
//   fire|=pix_fire.
//  No match: allocate the lowest-index free slot: box = {x,y,x,y}, count=1, fire=pix_fire.
//  No free slot: pixel dropped and working overflow set (sticky until next frame_start).
//  Pixels with pix_hot=0 are ignored. A pixel is never merged into more than one slot; slots are not re-merged
//   with each other.
//  frame_end in ACQ: the frame_end-cycle pixel is included, then at the next clock edge (PUB) the published
//   registers load:
//   busy[i]=wbusy[i]&&(count[i]>=MIN_PIX); box[i]=wbox[i] if busy[i] else 0; fire_out[i]=wfire[i]&&busy[i];
//   overflow=woverflow. frame_done=1 in that cycle.
//  frame_end outside ACQ is ignored. frame_start and frame_end in the same cycle: treated as a 1-cycle frame.
//  Published outputs hold between publishes, including across an aborted frame (a frame_start with no
//   frame_end, followed by a new frame_start).
//  Latency: frame_end edge -> outputs valid in 1 cycle.
// CONFIGURATION
//  HTPA_TRK_COUNT_EN defined: adds output obj_cnt [4:0] = popcount of published busy, registered with busy
//   (reset 0).
//  Not defined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset mid-ACQ with 3 slots active -> busy=0, box=0, overflow=0, frame_done=0 immediately;
//     frame_end ignored until next frame_start.
//  2. 2x2 hot block at (10,5)-(11,6) -> after frame_end: busy[0]=1, box[0]={10,5,11,6}, fire_out=0,
//     frame_done pulse 1 cycle later.
//  3. Pixels (0,0) and (2,2) with MARGIN=2 merge; (5,0) opens slot 1 -> both have count<4,
//     so busy=0 with MIN_PIX=4; with MIN_PIX=1: box0={0,0,2,2}, box1={5,0,5,0}.
//  4. 21 isolated hot pixels, 10 apart -> slots 0..19 filled, 21st dropped, overflow=1;
//     next frame with 1 pixel -> overflow=0.
//  5. One frame_start-cycle pixel (127,63,fire) plus 3 more at the same spot -> busy[0]=1,
//     box[0]={127,63,127,63}, fire_out[0]=1, no wrap.
//  6. With HTPA_TRK_COUNT_EN: 3 qualifying blobs -> obj_cnt=3 at frame_done; next empty frame -> obj_cnt=0.

Source files
------------

// File: rtl/htpa_target_builder.sv
// htpa_target_builder: clusters hot thermal pixels into up to N_TGT bounding boxes and publishes them
// once per frame as a stable set of slots for the box/overlay drawer.
// Latency: frame_end cycle -> published slots and the frame_done pulse valid one clock later.
// Backpressure: none; accepts one pixel per cycle with no stall, and a hot pixel that finds no slot is dropped.
//
// Optional build macro HTPA_TRK_COUNT_EN adds obj_cnt, the popcount of published busy.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   frame_start, frame_end  one-cycle frame delimiters
//   pix_valid/x/y/hot/fire  thresholded pixel stream
//   busy, box, fire_out     published slots; box slot i = box[26*i +: 26] = {xo,yo,xn,yn}
//   overflow                a hot pixel was dropped in the published frame
//   frame_done              one-cycle pulse when the published outputs update
//   obj_cnt                 (HTPA_TRK_COUNT_EN only) number of published busy slots
module htpa_target_builder #(
    parameter int N_TGT   = 20,
    parameter int MARGIN  = 2,
    parameter int MIN_PIX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic                   pix_valid,
    input  logic [6:0]             pix_x,
    input  logic [5:0]             pix_y,
    input  logic                   pix_hot,
    input  logic                   pix_fire,
    output logic [N_TGT-1:0]       busy,
    output logic [26*N_TGT-1:0]    box,
    output logic [N_TGT-1:0]       fire_out,
    output logic                   overflow,
    output logic                   frame_done
`ifdef HTPA_TRK_COUNT_EN
    ,
    output logic [4:0]             obj_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACQ, PUB} state_t;

    localparam logic [N_TGT-1:0] ONE = 1;
    localparam logic [7:0]       MX  = 8'(MARGIN);
    localparam logic [6:0]       MY  = 7'(MARGIN);
    localparam logic [7:0]       MIN = 8'(MIN_PIX);

    state_t state_q;

    // Working set, built up during the frame
    logic [N_TGT-1:0] wbusy_q, wbusy_d;
    logic [N_TGT-1:0] wfire_q, wfire_d;
    logic [6:0]       wxo_q [N_TGT];
    logic [6:0]       wxo_d [N_TGT];
    logic [5:0]       wyo_q [N_TGT];
    logic [5:0]       wyo_d [N_TGT];
    logic [6:0]       wxn_q [N_TGT];
    logic [6:0]       wxn_d [N_TGT];
    logic [5:0]       wyn_q [N_TGT];
    logic [5:0]       wyn_d [N_TGT];
    logic [7:0]       wcnt_q [N_TGT];
    logic [7:0]       wcnt_d [N_TGT];
    logic             wovf_q, wovf_d;

    logic             take;
    logic             pub_go;
    logic [N_TGT-1:0] hit, hit_oh, free_oh;
    logic [7:0]       px8;
    logic [6:0]       py7;
    logic [N_TGT-1:0] pub_busy;
    logic [26*N_TGT-1:0] pub_box;

    assign px8 = {1'b0, pix_x};
    assign py7 = {1'b0, pix_y};

    // A frame_start cycle is already part of the new frame, even from IDLE/PUB.
    assign take   = ((state_q == ACQ) || frame_start) && pix_valid && pix_hot;
    assign pub_go = frame_end && ((state_q == ACQ) || frame_start);

    always_comb begin
        // frame_start clears first so a pixel in the same cycle lands in a fresh set
        wbusy_d = frame_start ? '0 : wbusy_q;
        wfire_d = frame_start ? '0 : wfire_q;
        wovf_d  = frame_start ? 1'b0 : wovf_q;
        for (int i = 0; i < N_TGT; i++) begin
            wxo_d[i]  = wxo_q[i];
            wyo_d[i]  = wyo_q[i];
            wxn_d[i]  = wxn_q[i];
            wyn_d[i]  = wyn_q[i];
            wcnt_d[i] = frame_start ? 8'd0 : wcnt_q[i];
        end

        // Compares are one bit wider than the coordinates so the margin never wraps.
        for (int i = 0; i < N_TGT; i++) begin
            hit[i] = wbusy_d[i]
                  && (px8 + MX >= {1'b0, wxo_q[i]}) && (px8 <= {1'b0, wxn_q[i]} + MX)
                  && (py7 + MY >= {1'b0, wyo_q[i]}) && (py7 <= {1'b0, wyn_q[i]} + MY);
        end
        // Isolate the lowest matching slot and the lowest free slot.
        hit_oh  = hit & (~hit + ONE);
        free_oh = ~wbusy_d & (wbusy_d + ONE);

        if (take) begin
            if (|hit) begin
                for (int i = 0; i < N_TGT; i++) begin
                    if (hit_oh[i]) begin
                        if (pix_x < wxo_q[i]) wxo_d[i] = pix_x;
                        if (pix_x > wxn_q[i]) wxn_d[i] = pix_x;
                        if (pix_y < wyo_q[i]) wyo_d[i] = pix_y;
                        if (pix_y > wyn_q[i]) wyn_d[i] = pix_y;
                        if (wcnt_d[i] != 8'hFF) wcnt_d[i] = wcnt_d[i] + 8'd1;
                        wfire_d[i] = wfire_d[i] | pix_fire;
                    end
                end
            end else if (|free_oh) begin
                for (int i = 0; i < N_TGT; i++) begin
                    if (free_oh[i]) begin
                        wbusy_d[i] = 1'b1;
                        wxo_d[i]   = pix_x;
                        wxn_d[i]   = pix_x;
                        wyo_d[i]   = pix_y;
                        wyn_d[i]   = pix_y;
                        wcnt_d[i]  = 8'd1;
                        wfire_d[i] = pix_fire;
                    end
                end
            end else begin
                wovf_d = 1'b1;
            end
        end

        // Publish from next-state values so the frame_end-cycle pixel is included.
        for (int i = 0; i < N_TGT; i++) begin
            pub_busy[i] = wbusy_d[i] && (wcnt_d[i] >= MIN);
            pub_box[26*i +: 26] = pub_busy[i] ? {wxo_d[i], wyo_d[i], wxn_d[i], wyn_d[i]} : 26'd0;
        end
    end

`ifdef HTPA_TRK_COUNT_EN
    logic [4:0] pub_cnt;
    always_comb begin
        pub_cnt = 5'd0;
        for (int i = 0; i < N_TGT; i++) begin
            pub_cnt = pub_cnt + {4'd0, pub_busy[i]};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbusy_q <= '0;
            wfire_q <= '0;
            wovf_q  <= 1'b0;
            for (int i = 0; i < N_TGT; i++) begin
                wxo_q[i]  <= '0;
                wyo_q[i]  <= '0;
                wxn_q[i]  <= '0;
                wyn_q[i]  <= '0;
                wcnt_q[i] <= '0;
            end
        end else begin
            wbusy_q <= wbusy_d;
            wfire_q <= wfire_d;
            wovf_q  <= wovf_d;
            for (int i = 0; i < N_TGT; i++) begin
                wxo_q[i]  <= wxo_d[i];
                wyo_q[i]  <= wyo_d[i];
                wxn_q[i]  <= wxn_d[i];
                wyn_q[i]  <= wyn_d[i];
                wcnt_q[i] <= wcnt_d[i];
            end
        end
    end

    // Frame FSM with registered published outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy       <= '0;
            box        <= '0;
            fire_out   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
`ifdef HTPA_TRK_COUNT_EN
            obj_cnt    <= 5'd0;
`endif
        end else begin
            frame_done <= pub_go;
            if (pub_go) begin
                busy     <= pub_busy;
                box      <= pub_box;
                fire_out <= pub_busy & wfire_d;
                overflow <= wovf_d;
`ifdef HTPA_TRK_COUNT_EN
                obj_cnt  <= pub_cnt;
`endif
            end
            if (pub_go) begin
                state_q <= PUB;
            end else if (frame_start) begin
                state_q <= ACQ;
            end else if (state_q == PUB) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_htpa_target_builder.sv
module tb_htpa_target_builder;

    localparam int N = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start, frame_end, pix_valid, pix_hot, pix_fire;
    logic [6:0] pix_x;
    logic [5:0] pix_y;

    logic [N-1:0]    busy, fire_out, busy1, fire_out1;
    logic [26*N-1:0] box, box1;
    logic            overflow, frame_done, overflow1, frame_done1;
`ifdef HTPA_TRK_COUNT_EN
    logic [4:0]      obj_cnt, obj_cnt1;
`endif

    always #5 clk = ~clk;

    htpa_target_builder #(.N_TGT(N), .MARGIN(2), .MIN_PIX(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_hot(pix_hot), .pix_fire(pix_fire),
        .busy(busy), .box(box), .fire_out(fire_out), .overflow(overflow), .frame_done(frame_done)
`ifdef HTPA_TRK_COUNT_EN
        , .obj_cnt(obj_cnt)
`endif
    );

    // Same stream, MIN_PIX=1, so single-pixel slots become visible
    htpa_target_builder #(.N_TGT(N), .MARGIN(2), .MIN_PIX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_hot(pix_hot), .pix_fire(pix_fire),
        .busy(busy1), .box(box1), .fire_out(fire_out1), .overflow(overflow1), .frame_done(frame_done1)
`ifdef HTPA_TRK_COUNT_EN
        , .obj_cnt(obj_cnt1)
`endif
    );

    typedef struct {
        logic [N-1:0]    busy;
        logic [26*N-1:0] box;
        logic [N-1:0]    fire;
        logic            ovf;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [25:0] bx(input int xo, input int yo, input int xn, input int yn);
        return {7'(xo), 6'(yo), 7'(xn), 6'(yn)};
    endfunction

    function automatic exp_t empty_exp();
        exp_t e;
        e.busy = '0; e.box = '0; e.fire = '0; e.ovf = 1'b0;
        return e;
    endfunction

    task automatic drive(input logic fs, input logic fe, input logic v, input int x, input int y,
                         input logic hot, input logic fire);
        @(negedge clk);
        frame_start = fs; frame_end = fe; pix_valid = v;
        pix_x = 7'(x); pix_y = 6'(y); pix_hot = hot; pix_fire = fire;
    endtask

    // Bounded wait for frame_done after a frame_end cycle has been driven; lat=-1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            frame_start = 0; frame_end = 0; pix_valid = 0; pix_hot = 0; pix_fire = 0;
            if (frame_done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 0; frame_end = 0; pix_valid = 0; pix_x = 0; pix_y = 0; pix_hot = 0; pix_fire = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, fire_out, overflow, frame_done} !== '0) begin
            failures++;
            $display("FAIL reset_flags got busy=%h fire=%h ovf=%b done=%b exp all 0", busy, fire_out, overflow, frame_done);
        end
        checks++;
        if (box !== '0) begin
            failures++;
            $display("FAIL reset_box got=%h exp=0", box);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_block();
        exp_t e;
        int lat;
        e = empty_exp();
        e.busy[0] = 1'b1;
        e.box[25:0] = bx(10, 5, 11, 6);
        sb.push_back(e);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 10, 5, 1, 0);
        drive(0, 0, 1, 11, 5, 1, 0);
        drive(0, 0, 1, 10, 6, 1, 0);
        drive(0, 0, 1, 11, 6, 1, 0);
        drive(0, 0, 1, 90, 50, 0, 1);   // cold pixel, ignored
        drive(0, 1, 0, 0, 0, 0, 0);
        wait_done(lat);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=1", lat);
        end
        e = sb.pop_front();
        checks++;
        if ({busy, fire_out, overflow} !== {e.busy, e.fire, e.ovf}) begin
            failures++;
            $display("FAIL basic_flags got busy=%h fire=%h ovf=%b exp busy=%h fire=%h ovf=%b", busy, fire_out, overflow, e.busy, e.fire, e.ovf);
        end
        checks++;
        if (box !== e.box) begin
            failures++;
            $display("FAIL basic_box got=%h exp=%h", box, e.box);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_reset_mid_acq();
        int lat;
        drive(1, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 1, 50, 20, 1, 0);
        drive(0, 0, 1, 100, 40, 1, 1);
        @(negedge clk);
        pix_valid = 0; pix_hot = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, fire_out, overflow, frame_done} !== '0 || box !== '0) begin
            failures++;
            $display("FAIL midreset_clear got busy=%h box=%h ovf=%b done=%b exp all 0", busy, box, overflow, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 1, 5, 5, 1, 0);    // frame_end with no open frame
        wait_done(lat);
        checks++;
        if (lat != -1) begin
            failures++;
            $display("FAIL midreset_fe_ignored got done_latency=%0d exp none", lat);
        end
        checks++;
        if (busy1 !== '0) begin
            failures++;
            $display("FAIL midreset_hold got busy1=%h exp=0", busy1);
        end
    endtask

    task automatic test_merge_margin();
        exp_t e;
        int lat;
        logic [26*N-1:0] eb1;
        e = empty_exp();
        sb.push_back(e);
        eb1 = '0;
        eb1[25:0]  = bx(0, 0, 2, 2);
        eb1[51:26] = bx(5, 0, 5, 0);
        drive(1, 0, 1, 0, 0, 1, 0);     // frame_start-cycle pixel
        drive(0, 0, 1, 2, 2, 1, 0);
        drive(0, 1, 1, 5, 0, 1, 0);     // frame_end-cycle pixel
        wait_done(lat);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL merge_latency got=%0d exp=1", lat);
        end
        e = sb.pop_front();
        checks++;
        if ({busy, fire_out, overflow} !== {e.busy, e.fire, e.ovf} || box !== e.box) begin
            failures++;
            $display("FAIL merge_minpix4 got busy=%h box=%h exp busy=%h box=%h", busy, box, e.busy, e.box);
        end
        checks++;
        if (busy1 !== 20'h3 || box1 !== eb1) begin
            failures++;
            $display("FAIL merge_minpix1 got busy=%h box=%h exp busy=3 box=%h", busy1, box1, eb1);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int lat;
        logic [26*N-1:0] eb1;
        e = empty_exp();
        e.ovf = 1'b1;
        sb.push_back(e);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 21; k++) begin
            drive(0, 0, 1, (k % 10) * 10, (k / 10) * 10, 1, (k == 3));
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 1 || {busy, fire_out, overflow} !== {e.busy, e.fire, e.ovf}) begin
            failures++;
            $display("FAIL ovf_set got lat=%0d busy=%h fire=%h ovf=%b exp lat=1 busy=0 fire=0 ovf=1", lat, busy, fire_out, overflow);
        end
        checks++;
        if (busy1 !== 20'hFFFFF || fire_out1 !== 20'h8 || overflow1 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_slots got busy1=%h fire1=%h ovf1=%b exp busy1=fffff fire1=8 ovf1=1", busy1, fire_out1, overflow1);
        end
        checks++;
        if (box1[26*19 +: 26] !== bx(90, 10, 90, 10)) begin
            failures++;
            $display("FAIL ovf_slot19 got=%h exp=%h", box1[26*19 +: 26], bx(90, 10, 90, 10));
        end
        // Next frame: a single pixel clears the sticky overflow
        e = empty_exp();
        sb.push_back(e);
        eb1 = '0;
        eb1[25:0] = bx(60, 30, 60, 30);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 60, 30, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 1 || {busy, fire_out, overflow} !== {e.busy, e.fire, e.ovf}) begin
            failures++;
            $display("FAIL ovf_clear got lat=%0d busy=%h ovf=%b exp lat=1 busy=0 ovf=0", lat, busy, overflow);
        end
        checks++;
        if (busy1 !== 20'h1 || box1 !== eb1 || overflow1 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear_slot got busy1=%h box1=%h ovf1=%b exp busy1=1 box1=%h ovf1=0", busy1, box1, overflow1, eb1);
        end
    endtask

    task automatic test_corner_fire();
        exp_t e;
        int lat;
        e = empty_exp();
        e.busy[0] = 1'b1;
        e.fire[0] = 1'b1;
        e.box[25:0] = bx(127, 63, 127, 63);
        sb.push_back(e);
        drive(1, 0, 1, 127, 63, 1, 1);
        repeat (3) drive(0, 0, 1, 127, 63, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 1 || {busy, fire_out, overflow} !== {e.busy, e.fire, e.ovf}) begin
            failures++;
            $display("FAIL corner_flags got lat=%0d busy=%h fire=%h ovf=%b exp lat=1 busy=%h fire=%h ovf=0", lat, busy, fire_out, overflow, e.busy, e.fire);
        end
        checks++;
        if (box !== e.box) begin
            failures++;
            $display("FAIL corner_box got=%h exp=%h", box, e.box);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int lat;
        e = empty_exp();
        e.busy[0] = 1'b1;
        e.box[25:0] = bx(40, 40, 40, 40);
        sb.push_back(e);
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 1, 30, 30, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);     // abort: restart the frame
        repeat (4) drive(0, 0, 1, 40, 40, 1, 0);
        @(negedge clk);
        pix_valid = 0; pix_hot = 0;
        checks++;
        if (busy !== 20'h1 || box[25:0] !== bx(127, 63, 127, 63) || fire_out !== 20'h1) begin
            failures++;
            $display("FAIL abort_hold got busy=%h box0=%h fire=%h exp busy=1 box0=%h fire=1", busy, box[25:0], fire_out, bx(127, 63, 127, 63));
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 1 || {busy, fire_out, overflow} !== {e.busy, e.fire, e.ovf} || box !== e.box) begin
            failures++;
            $display("FAIL abort_publish got lat=%0d busy=%h box=%h exp lat=1 busy=%h box=%h", lat, busy, box, e.busy, e.box);
        end
    endtask

    task automatic test_one_cycle_frame();
        exp_t e;
        int lat;
        e = empty_exp();
        sb.push_back(e);
        drive(1, 1, 1, 3, 4, 1, 0);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 1 || {busy, fire_out, overflow} !== {e.busy, e.fire, e.ovf} || box !== e.box) begin
            failures++;
            $display("FAIL onecycle_minpix4 got lat=%0d busy=%h ovf=%b exp lat=1 busy=0 ovf=0", lat, busy, overflow);
        end
        checks++;
        if (busy1 !== 20'h1 || box1[25:0] !== bx(3, 4, 3, 4)) begin
            failures++;
            $display("FAIL onecycle_minpix1 got busy1=%h box0=%h exp busy1=1 box0=%h", busy1, box1[25:0], bx(3, 4, 3, 4));
        end
    endtask

`ifdef HTPA_TRK_COUNT_EN
    task automatic test_obj_count();
        int lat;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            repeat (4) drive(0, 0, 1, 10 + 40 * b, 10, 1, 0);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        wait_done(lat);
        checks++;
        if (lat != 1 || obj_cnt !== 5'd3 || busy !== 20'h7) begin
            failures++;
            $display("FAIL objcnt_three got lat=%0d obj_cnt=%0d busy=%h exp lat=1 obj_cnt=3 busy=7", lat, obj_cnt, busy);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        wait_done(lat);
        checks++;
        if (lat != 1 || obj_cnt !== 5'd0) begin
            failures++;
            $display("FAIL objcnt_empty got lat=%0d obj_cnt=%0d exp lat=1 obj_cnt=0", lat, obj_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_block();
        test_reset_mid_acq();
        test_merge_margin();
        test_overflow();
        test_corner_fire();
        test_abort();
        test_one_cycle_frame();
`ifdef HTPA_TRK_COUNT_EN
        test_obj_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
